// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg: shared rename-packet type and pipeline width constants.
package inst_buffer_pkg;
  localparam int FETCH_WIDTH    = 4;
  localparam int DISPATCH_WIDTH = 4;
  localparam int REN_PKT_SIZE   = 32;
  typedef struct packed {
    logic                    valid;
    logic [REN_PKT_SIZE-2:0] payload;
  } renPkt;
endpackage

// File: rtl/inst_buf_compact.sv
// inst_buf_compact: prefix count of valid lanes giving each lane its write offset and the total.
module inst_buf_compact #(
  parameter int N = 4,
  localparam int OW = $clog2(N + 1)
) (
  input  logic [N-1:0]         valid_i,
  output logic [N-1:0][OW-1:0] off_o,
  output logic [OW-1:0]        n_wr_o
);
  always_comb begin
    n_wr_o = '0;
    for (int k = 0; k < N; k++) begin
      off_o[k] = n_wr_o;
      n_wr_o   = n_wr_o + OW'(valid_i[k]);
    end
  end
endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: circular queue compacting sparse decode lanes and releasing exact dispatch bundles.
module inst_buffer #(
  parameter int DEPTH          = 32,
  parameter int DECODE_WIDTH   = inst_buffer_pkg::FETCH_WIDTH,
  parameter int DISPATCH_WIDTH = inst_buffer_pkg::DISPATCH_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             flush_i,
  input  logic                                             stall_i,
  input  logic                                             decodeReady_i,
  input  inst_buffer_pkg::renPkt [DECODE_WIDTH-1:0]        decPacket_i,
  output inst_buffer_pkg::renPkt [DISPATCH_WIDTH-1:0]      renPacket_o,
  output logic                                             instBufferReady_o,
  output logic                                             instBufferFull_o,
  output logic [$clog2(DEPTH):0]                           instCount_o
);
  import inst_buffer_pkg::*;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(DECODE_WIDTH + 1);
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  renPkt mem_q [DEPTH];
  logic [DECODE_WIDTH-1:0] dec_valid;
  logic [DECODE_WIDTH-1:0][OW-1:0] off;
  logic [OW-1:0] n_wr;
  logic wr_en, rd_en;
  always_comb begin
    dec_valid = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) dec_valid[k] = decPacket_i[k].valid;
  end
  inst_buf_compact #(.N(DECODE_WIDTH)) u_compact (
    .valid_i (dec_valid),
    .off_o   (off),
    .n_wr_o  (n_wr)
  );
  assign instBufferReady_o = count_q >= CW'(DISPATCH_WIDTH);
  assign instBufferFull_o  = (CW'(DEPTH) - count_q) < CW'(DECODE_WIDTH);
  assign instCount_o       = count_q;
  assign wr_en   = decodeReady_i & ~instBufferFull_o & ~flush_i;
  assign rd_en   = instBufferReady_o & ~stall_i & ~flush_i;
  assign count_d = count_q + (wr_en ? CW'(n_wr) : CW'(0)) - (rd_en ? CW'(DISPATCH_WIDTH) : CW'(0));
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + (rd_en ? PW'(DISPATCH_WIDTH) : PW'(0));
      tail_q  <= tail_q + (wr_en ? PW'(n_wr) : PW'(0));
      count_q <= count_d;
    end
  end
  // Storage is left unreset; lanes beyond count are masked by valid gating.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DECODE_WIDTH; k++)
      if (reset && wr_en && dec_valid[k]) mem_q[tail_q + PW'(off[k])] <= decPacket_i[k];
  end
  always_comb begin
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      renPacket_o[j]       = mem_q[head_q + PW'(j)];
      renPacket_o[j].valid = renPacket_o[j].valid & instBufferReady_o;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) count_q <= CW'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) rd_en |-> count_q >= CW'(DISPATCH_WIDTH));
  a_no_write_full: assert property (@(posedge clk) disable iff (!reset) !(wr_en && instBufferFull_o));
endmodule
